hier_icache_bank_ctrl_fsm: RTL and testbench

Per-bank control sequencer inside each shared (main) icache bank. It consumes the enable, disable, flush and selective-flush request/ack handshakes driven by the icache control unit, one instance per SP_ICACHE_CTRL_UNIT_BUS. It blocks new lookups, drains outstanding refills, and sweeps or probes the bank's tag RAM to invalidate lines. It also performs the power-on tag invalidation sweep.

---
 rtl/hier_icache_ctrl_pkg.sv | 46 ++++
 rtl/hier_icache_tag_sweep.sv | 49 ++++
 rtl/hier_icache_bank_ctrl_fsm.sv | 236 +++++++++++++++++++++++
 tb/tb_hier_icache_bank_ctrl_fsm.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hier_icache_ctrl_pkg.sv
// Shared definitions for the icache bank control sequencer.
// Holds the bank geometry, the sequencer state and request encodings, the
// tag-RAM entry layout and the helpers that split a fetch address into
// set index and tag.
package hier_icache_ctrl_pkg;

    localparam int NB_WAYS    = 4;
    localparam int NB_SETS    = 64;
    localparam int SET_ID_LSB = 4;
    localparam int TAG_WIDTH  = 22;
    localparam int ADDR_WIDTH = 32;
    localparam int SET_W      = $clog2(NB_SETS);
    localparam int ENTRY_W    = TAG_WIDTH + 1;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_DRAIN,
        ST_WALK,
        ST_SEL_RD,
        ST_SEL_CMP,
        ST_ACK,
        ST_WAIT_LOW
    } ctrl_state_e;

    typedef enum logic [1:0] {
        REQ_ENABLE,
        REQ_DISABLE,
        REQ_FLUSH,
        REQ_SEL_FLUSH
    } ctrl_req_e;

    typedef struct packed {
        logic                 valid;
        logic [TAG_WIDTH-1:0] tag;
    } tag_entry_t;

    function automatic logic [SET_W-1:0] addr_set(input logic [ADDR_WIDTH-1:0] addr);
        return addr[SET_ID_LSB +: SET_W];
    endfunction

    function automatic logic [TAG_WIDTH-1:0] addr_tag(input logic [ADDR_WIDTH-1:0] addr);
        return addr[SET_ID_LSB + SET_W +: TAG_WIDTH];
    endfunction

endpackage

// File: rtl/hier_icache_tag_sweep.sv
// Set counter that walks every set of the bank once, one set per cycle.
// Used both for the power-on invalidation and for full flush/disable walks.
//   clk_i, rst_i : clock, synchronous active-high reset (arms a sweep)
//   start_i      : restart the sweep at set 0
//   set_idx_o    : set currently being visited
//   busy_o       : sweep in progress (set_idx_o is valid)
//   done_o       : last set is being visited this cycle
module hier_icache_tag_sweep
    import hier_icache_ctrl_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    output logic [SET_W-1:0] set_idx_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [SET_W-1:0] LAST_SET = SET_W'(NB_SETS - 1);

    logic [SET_W-1:0] set_cnt_r;
    logic             busy_r;

    // Set counter: reset arms the power-on sweep, start re-arms it for a walk.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            set_cnt_r <= {SET_W{1'b0}};
            busy_r    <= 1'b1;
        end else if (start_i) begin
            set_cnt_r <= {SET_W{1'b0}};
            busy_r    <= 1'b1;
        end else if (busy_r) begin
            if (set_cnt_r == LAST_SET) begin
                set_cnt_r <= {SET_W{1'b0}};
                busy_r    <= 1'b0;
            end else begin
                set_cnt_r <= set_cnt_r + SET_W'(1);
            end
        end else begin
            set_cnt_r <= set_cnt_r;
            busy_r    <= busy_r;
        end
    end

    assign set_idx_o = set_cnt_r;
    assign busy_o    = busy_r;
    assign done_o    = busy_r && (set_cnt_r == LAST_SET);

endmodule

// File: rtl/hier_icache_bank_ctrl_fsm.sv
// Per-bank control sequencer of a shared icache bank.
// Serves enable / disable / flush / selective-flush handshakes from the icache
// control unit: blocks lookups, waits for outstanding refills, then sweeps or
// probes the tag RAM to invalidate lines. Also runs the power-on tag sweep.
//   ctrl_req_enable_i / ctrl_ack_enable_o   : enable request level / ack pulse
//   ctrl_req_disable_i / ctrl_ack_disable_o : disable request level / ack pulse
//   ctrl_flush_req_i / ctrl_flush_ack_o     : full flush request level / ack pulse
//   sel_flush_req_i / sel_flush_ack_o       : selective flush request / ack pulse
//   sel_flush_addr_i                        : address to invalidate (latched on accept)
//   pending_refill_i                        : refills still outstanding to L2
//   fetch_block_o, cache_enabled_o          : lookup block, cached (1) / bypass (0)
//   tag_req_o/tag_we_o/tag_addr_o/tag_way_be_o/tag_wdata_o/tag_rdata_i : tag RAM port
module hier_icache_bank_ctrl_fsm
    import hier_icache_ctrl_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       ctrl_req_enable_i,
    output logic                       ctrl_ack_enable_o,
    input  logic                       ctrl_req_disable_i,
    output logic                       ctrl_ack_disable_o,
    input  logic                       ctrl_flush_req_i,
    output logic                       ctrl_flush_ack_o,
    input  logic                       sel_flush_req_i,
    input  logic [ADDR_WIDTH-1:0]      sel_flush_addr_i,
    output logic                       sel_flush_ack_o,
    input  logic                       pending_refill_i,
    output logic                       fetch_block_o,
    output logic                       cache_enabled_o,
    output logic                       tag_req_o,
    output logic                       tag_we_o,
    output logic [SET_W-1:0]           tag_addr_o,
    output logic [NB_WAYS-1:0]         tag_way_be_o,
    output logic [ENTRY_W-1:0]         tag_wdata_o,
    input  logic [NB_WAYS*ENTRY_W-1:0] tag_rdata_i
);

    ctrl_state_e          state_r, state_next_s;
    ctrl_req_e            kind_r, kind_next_s;
    logic [SET_W-1:0]     sel_set_r;
    logic [TAG_WIDTH-1:0] sel_tag_r;
    logic                 cache_en_r;
    logic                 addr_load_s;
    logic                 sweep_start_s;
    logic                 sweep_busy_s;
    logic                 sweep_done_s;
    logic [SET_W-1:0]     sweep_set_s;
    logic                 kind_req_s;
    logic [NB_WAYS-1:0]   hit_s;
    tag_entry_t           entry_s;
    logic                 addr_offset_unused_s;

    // Line-offset bits select nothing in the tag RAM.
    assign addr_offset_unused_s = ^sel_flush_addr_i[SET_ID_LSB-1:0];

    hier_icache_tag_sweep u_sweep (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (sweep_start_s),
        .set_idx_o (sweep_set_s),
        .busy_o    (sweep_busy_s),
        .done_o    (sweep_done_s)
    );

    // Level of the request that is currently being served.
    always_comb begin
        kind_req_s = 1'b0;
        case (kind_r)
            REQ_ENABLE:    kind_req_s = ctrl_req_enable_i;
            REQ_DISABLE:   kind_req_s = ctrl_req_disable_i;
            REQ_FLUSH:     kind_req_s = ctrl_flush_req_i;
            REQ_SEL_FLUSH: kind_req_s = sel_flush_req_i;
            default:       kind_req_s = 1'b0;
        endcase
    end

    // Per-way hit of the probed set against the latched flush tag.
    always_comb begin
        hit_s   = {NB_WAYS{1'b0}};
        entry_s = tag_entry_t'({ENTRY_W{1'b0}});
        for (int w = 0; w < NB_WAYS; w++) begin
            entry_s  = tag_entry_t'(tag_rdata_i[w*ENTRY_W +: ENTRY_W]);
            hit_s[w] = entry_s.valid && (entry_s.tag == sel_tag_r);
        end
    end

    // Next-state logic; request priority in IDLE is disable > flush > sel > enable.
    always_comb begin
        state_next_s  = state_r;
        kind_next_s   = kind_r;
        addr_load_s   = 1'b0;
        sweep_start_s = 1'b0;
        case (state_r)
            ST_INIT: begin
                if (sweep_done_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (ctrl_req_disable_i) begin
                    kind_next_s  = REQ_DISABLE;
                    state_next_s = ST_DRAIN;
                end else if (ctrl_flush_req_i) begin
                    kind_next_s  = REQ_FLUSH;
                    state_next_s = ST_DRAIN;
                end else if (sel_flush_req_i) begin
                    kind_next_s  = REQ_SEL_FLUSH;
                    addr_load_s  = 1'b1;
                    state_next_s = ST_DRAIN;
                end else if (ctrl_req_enable_i) begin
                    kind_next_s  = REQ_ENABLE;
                    state_next_s = ST_ACK;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (pending_refill_i) begin
                    state_next_s = ST_DRAIN;
                end else if (kind_r == REQ_SEL_FLUSH) begin
                    state_next_s = ST_SEL_RD;
                end else begin
                    sweep_start_s = 1'b1;
                    state_next_s  = ST_WALK;
                end
            end
            ST_WALK: begin
                if (sweep_done_s) begin
                    state_next_s = ST_ACK;
                end else begin
                    state_next_s = ST_WALK;
                end
            end
            ST_SEL_RD:  state_next_s = ST_SEL_CMP;
            ST_SEL_CMP: state_next_s = ST_ACK;
            ST_ACK:     state_next_s = ST_WAIT_LOW;
            ST_WAIT_LOW: begin
                if (kind_req_s) begin
                    state_next_s = ST_WAIT_LOW;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: state_next_s = ST_INIT;
        endcase
    end

    // State, accepted request kind and latched flush address.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= ST_INIT;
            kind_r    <= REQ_ENABLE;
            sel_set_r <= {SET_W{1'b0}};
            sel_tag_r <= {TAG_WIDTH{1'b0}};
        end else begin
            state_r <= state_next_s;
            kind_r  <= kind_next_s;
            if (addr_load_s) begin
                sel_set_r <= addr_set(sel_flush_addr_i);
                sel_tag_r <= addr_tag(sel_flush_addr_i);
            end else begin
                sel_set_r <= sel_set_r;
                sel_tag_r <= sel_tag_r;
            end
        end
    end

    // Cached-mode flag changes on entry to ACK so it is visible with the ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cache_en_r <= 1'b0;
        end else if ((state_next_s == ST_ACK) && (kind_next_s == REQ_ENABLE)) begin
            cache_en_r <= 1'b1;
        end else if ((state_next_s == ST_ACK) && (kind_next_s == REQ_DISABLE)) begin
            cache_en_r <= 1'b0;
        end else begin
            cache_en_r <= cache_en_r;
        end
    end

    assign cache_enabled_o = cache_en_r;

    // Output decode; reset silences the tag port even before state settles.
    always_comb begin
        tag_req_o          = 1'b0;
        tag_we_o           = 1'b0;
        tag_addr_o         = {SET_W{1'b0}};
        tag_way_be_o       = {NB_WAYS{1'b0}};
        tag_wdata_o        = {ENTRY_W{1'b0}};
        ctrl_ack_enable_o  = 1'b0;
        ctrl_ack_disable_o = 1'b0;
        ctrl_flush_ack_o   = 1'b0;
        sel_flush_ack_o    = 1'b0;
        fetch_block_o      = 1'b1;
        if (rst_i) begin
            fetch_block_o = 1'b1;
        end else begin
            case (state_r)
                ST_INIT, ST_WALK: begin
                    tag_req_o    = sweep_busy_s;
                    tag_we_o     = sweep_busy_s;
                    tag_addr_o   = sweep_set_s;
                    tag_way_be_o = {NB_WAYS{sweep_busy_s}};
                end
                ST_IDLE: fetch_block_o = 1'b0;
                ST_SEL_RD: begin
                    tag_req_o  = 1'b1;
                    tag_addr_o = sel_set_r;
                end
                ST_SEL_CMP: begin
                    if (|hit_s) begin
                        tag_req_o    = 1'b1;
                        tag_we_o     = 1'b1;
                        tag_addr_o   = sel_set_r;
                        tag_way_be_o = hit_s;
                    end else begin
                        tag_req_o = 1'b0;
                    end
                end
                ST_ACK: begin
                    case (kind_r)
                        REQ_ENABLE:    ctrl_ack_enable_o  = 1'b1;
                        REQ_DISABLE:   ctrl_ack_disable_o = 1'b1;
                        REQ_FLUSH:     ctrl_flush_ack_o   = 1'b1;
                        REQ_SEL_FLUSH: sel_flush_ack_o    = 1'b1;
                        default:       ctrl_ack_enable_o  = 1'b0;
                    endcase
                end
                default: fetch_block_o = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_hier_icache_bank_ctrl_fsm.sv
// Self-checking bench for hier_icache_bank_ctrl_fsm. Each transaction's
// expected timeline (ack cycle, tag-RAM accesses, lookup blocking, cached-mode
// flag) is derived arithmetically from the request kind and refill-drain
// length; bank contents are tracked in reference valid/tag arrays.
module tb_hier_icache_bank_ctrl_fsm;
    import hier_icache_ctrl_pkg::*;

    localparam int K_EN = 0, K_DIS = 1, K_FL = 2, K_SEL = 3;

    logic clk = 1'b0;
    logic rst, req_en, req_dis, fl_req, sel_req, pending;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic ack_en, ack_dis, fl_ack, sel_ack, fetch_block, cache_en, tag_req, tag_we;
    logic [SET_W-1:0] tag_addr;
    logic [NB_WAYS-1:0] tag_be;
    logic [ENTRY_W-1:0] tag_wdata;
    logic [NB_WAYS*ENTRY_W-1:0] tag_rdata;

    int n_vec = 0, n_err = 0, cyc = 0;
    logic [ENTRY_W-1:0] mem [NB_SETS][NB_WAYS];
    logic ref_valid [NB_SETS][NB_WAYS];
    logic [TAG_WIDTH-1:0] ref_tag [NB_SETS][NB_WAYS];
    logic ref_en;
    logic pre_we = 1'b0;
    int pre_set = 0, pre_way = 0;
    logic [ENTRY_W-1:0] pre_data = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hier_icache_bank_ctrl_fsm dut (
        .clk_i(clk), .rst_i(rst),
        .ctrl_req_enable_i(req_en), .ctrl_ack_enable_o(ack_en),
        .ctrl_req_disable_i(req_dis), .ctrl_ack_disable_o(ack_dis),
        .ctrl_flush_req_i(fl_req), .ctrl_flush_ack_o(fl_ack),
        .sel_flush_req_i(sel_req), .sel_flush_addr_i(sel_addr), .sel_flush_ack_o(sel_ack),
        .pending_refill_i(pending), .fetch_block_o(fetch_block), .cache_enabled_o(cache_en),
        .tag_req_o(tag_req), .tag_we_o(tag_we), .tag_addr_o(tag_addr),
        .tag_way_be_o(tag_be), .tag_wdata_o(tag_wdata), .tag_rdata_i(tag_rdata)
    );

    // Tag RAM model: byte-enabled ways, 1-cycle read latency, preload port.
    always @(posedge clk) begin
        if (pre_we) mem[pre_set][pre_way] <= pre_data;
        if (tag_req && tag_we) begin
            for (int w = 0; w < NB_WAYS; w++)
                if (tag_be[w]) mem[tag_addr][w] <= tag_wdata;
        end
        if (tag_req && !tag_we) begin
            for (int w = 0; w < NB_WAYS; w++)
                tag_rdata[w*ENTRY_W +: ENTRY_W] <= mem[tag_addr][w];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Tag-port view: address only meaningful with req, enables/data only on writes.
    function automatic logic [63:0] pack_bus(input logic rq, input logic we, input logic [SET_W-1:0] ad,
                                             input logic [NB_WAYS-1:0] be, input logic [ENTRY_W-1:0] wd);
        logic wr;
        wr = rq & we;
        return 64'({rq, we, rq ? ad : {SET_W{1'b0}}, wr ? be : {NB_WAYS{1'b0}}, wr ? wd : {ENTRY_W{1'b0}}});
    endfunction

    function automatic logic [63:0] ack_vec();
        return 64'({sel_ack, fl_ack, ack_dis, ack_en});
    endfunction

    task automatic drive_quiet();
        {req_en, req_dis, fl_req, sel_req, pending, rst} = 6'b0;
        sel_addr = '0;
    endtask

    task automatic clear_refs();
        for (int s = 0; s < NB_SETS; s++)
            for (int w = 0; w < NB_WAYS; w++) ref_valid[s][w] = 1'b0;
    endtask

    task automatic preload(input int s, input int w, input logic [TAG_WIDTH-1:0] t);
        drive_quiet();
        pre_set = s; pre_way = w; pre_data = {1'b1, t}; pre_we = 1'b1;
        @(posedge clk); #1;
        pre_we = 1'b0;
        ref_valid[s][w] = 1'b1;
        ref_tag[s][w] = t;
    endtask

    // Power-on sweep: sets 0..NB_SETS-1 written with zero, lookups blocked until it ends.
    task automatic check_init();
        drive_quiet();
        for (int k = 0; k <= NB_SETS; k++) begin
            @(negedge clk);
            if (k < NB_SETS)
                check_eq("init_bus", pack_bus(tag_req, tag_we, tag_addr, tag_be, tag_wdata),
                         pack_bus(1'b1, 1'b1, SET_W'(k), {NB_WAYS{1'b1}}, '0));
            else
                check_eq("init_bus_end", pack_bus(tag_req, tag_we, tag_addr, tag_be, tag_wdata), 64'd0);
            check_eq("init_fetch_block", 64'(fetch_block), 64'(k < NB_SETS));
            check_eq("init_ack", ack_vec(), 64'd0);
            check_eq("init_cache_en", 64'(cache_en), 64'd0);
            @(posedge clk); #1;
        end
        clear_refs();
        ref_en = 1'b0;
    endtask

    // One handshake accepted at cycle 0; refill pending for cycles 0..p-1;
    // request held until `extra` cycles past the ack; optional reset at rst_at.
    task automatic run_txn(input int kind, input int extra, input int p, input logic [ADDR_WIDTH-1:0] addr,
                           input bit other_en, input bit noise, input int rst_at);
        int c, ack_k, hold, last_k, s;
        logic [TAG_WIDTH-1:0] t;
        logic [NB_WAYS-1:0] hit, e_be;
        logic [3:0] req_v, nz, exp_ack;
        logic e_req, e_we, e_en;
        logic [SET_W-1:0] e_addr;
        c = (p > 1) ? p : 1;
        s = int'((addr >> SET_ID_LSB) % NB_SETS);
        t = TAG_WIDTH'(addr >> (SET_ID_LSB + SET_W));
        hit = '0;
        for (int w = 0; w < NB_WAYS; w++)
            if (ref_valid[s][w] && ref_tag[s][w] == t) hit[w] = 1'b1;
        if (kind == K_EN) ack_k = 1;
        else if (kind == K_SEL) ack_k = c + 3;
        else ack_k = c + 1 + NB_SETS;
        hold = ack_k + extra;
        last_k = (rst_at >= 0) ? rst_at : hold;
        for (int k = 0; k <= last_k; k++) begin
            req_v = 4'b0;
            if (k < hold) req_v[kind] = 1'b1;
            if (other_en) req_v[K_EN] = 1'b1;
            if (noise && k >= 1) begin
                nz = 4'($urandom_range(15, 0));
                nz[kind] = 1'b0;
                req_v = req_v | nz;
            end
            req_en = req_v[K_EN]; req_dis = req_v[K_DIS]; fl_req = req_v[K_FL]; sel_req = req_v[K_SEL];
            if (kind == K_EN || k > c) pending = 1'($urandom_range(1, 0));
            else pending = (k < p);
            sel_addr = (k == 0) ? addr : ADDR_WIDTH'($urandom);
            rst = (k == rst_at);
            @(negedge clk);
            exp_ack = 4'b0;
            if (k == ack_k) exp_ack[kind] = 1'b1;
            check_eq("ack", ack_vec(), 64'(exp_ack));
            e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_be = '0;
            if ((kind == K_DIS || kind == K_FL) && k >= c + 1 && k <= c + NB_SETS) begin
                e_req = 1'b1; e_we = 1'b1; e_addr = SET_W'(k - c - 1); e_be = '1;
            end
            if (kind == K_SEL && k == c + 1) begin
                e_req = 1'b1; e_addr = SET_W'(s);
            end
            if (kind == K_SEL && k == c + 2 && hit != 0) begin
                e_req = 1'b1; e_we = 1'b1; e_addr = SET_W'(s); e_be = hit;
            end
            if (k == rst_at) begin
                e_req = 1'b0; e_we = 1'b0;
            end
            check_eq("tag_bus", pack_bus(tag_req, tag_we, tag_addr, tag_be, tag_wdata),
                     pack_bus(e_req, e_we, e_addr, e_be, '0));
            if (k == 0) check_eq("fetch_block_idle", 64'(fetch_block), 64'd0);
            else if (kind != K_EN) check_eq("fetch_block_busy", 64'(fetch_block), 64'd1);
            if (k != rst_at) begin
                e_en = ref_en;
                if (kind == K_EN && k >= 1) e_en = 1'b1;
                if (kind == K_DIS && k >= ack_k) e_en = 1'b0;
                check_eq("cache_en", 64'(cache_en), 64'(e_en));
            end
            @(posedge clk); #1;
        end
        if (rst_at >= 0) begin
            ref_en = 1'b0;
            clear_refs();
        end else begin
            case (kind)
                K_EN:  ref_en = 1'b1;
                K_DIS: begin ref_en = 1'b0; clear_refs(); end
                K_FL:  clear_refs();
                default: for (int w = 0; w < NB_WAYS; w++) if (hit[w]) ref_valid[s][w] = 1'b0;
            endcase
        end
    endtask

    function automatic logic [ADDR_WIDTH-1:0] mk_addr(input logic [TAG_WIDTH-1:0] t, input int s, input int off);
        return (ADDR_WIDTH'(t) << (SET_ID_LSB + SET_W)) | (ADDR_WIDTH'(s) << SET_ID_LSB) | ADDR_WIDTH'(off);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind, s, w;
        logic [ADDR_WIDTH-1:0] a;
        drive_quiet();
        rst = 1'b1;
        ref_en = 1'b0;
        clear_refs();
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check_eq("rst_ack", ack_vec(), 64'd0);
        check_eq("rst_tag_req", 64'(tag_req), 64'd0);
        check_eq("rst_fetch_block", 64'(fetch_block), 64'd1);
        check_eq("rst_cache_en", 64'(cache_en), 64'd0);
        @(posedge clk); #1;
        check_init();

        run_txn(K_EN, 4, 0, '0, 1'b0, 1'b0, -1);
        run_txn(K_FL, 3, 3, '0, 1'b0, 1'b0, -1);
        preload(5, 2, 22'h1234);
        run_txn(K_SEL, 2, 0, mk_addr(22'h1234, 5, 0), 1'b0, 1'b0, -1);
        preload(5, 2, 22'h1234);
        run_txn(K_SEL, 2, 0, mk_addr(22'h0999, 5, 0), 1'b0, 1'b0, -1);
        run_txn(K_DIS, 2, 0, '0, 1'b1, 1'b0, -1);
        run_txn(K_EN, 2, 0, '0, 1'b0, 1'b0, -1);

        for (int n = 0; n < 30; n++) begin
            for (int j = 0; j < 3; j++)
                preload($urandom_range(NB_SETS - 1, 0), $urandom_range(NB_WAYS - 1, 0),
                        TAG_WIDTH'($urandom_range(7, 0)));
            kind = $urandom_range(3, 0);
            s = $urandom_range(NB_SETS - 1, 0);
            w = $urandom_range(NB_WAYS - 1, 0);
            a = mk_addr(TAG_WIDTH'($urandom_range(7, 0)), s, $urandom_range(15, 0));
            if (ref_valid[s][w] && $urandom_range(1, 0) == 1)
                a = mk_addr(ref_tag[s][w], s, $urandom_range(15, 0));
            run_txn(kind, $urandom_range(4, 1), $urandom_range(5, 0), a, 1'b0, 1'b1, -1);
        end

        run_txn(K_EN, 1, 0, '0, 1'b0, 1'b0, -1);
        run_txn(K_FL, 1, 0, '0, 1'b0, 1'b0, 22);
        check_init();
        run_txn(K_EN, 1, 0, '0, 1'b0, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
